// File: rtl/adder_sum_stage_pkg.sv
// Shared definitions for the ALU adder sum stage: operand size codes,
// status-flag bit positions and the skid-buffer state encoding.
// Latency: n/a (package). Backpressure: n/a.
package adder_sum_stage_pkg;

  // Default operand width of the ALU datapath.
  localparam int LEN_DATA = 32;

  // Operand size selector; 2'b11 is reserved and decodes as a word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Bit positions of the flags inside the packed status nibble, matching
  // the status-register layout.
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } skid_state_e;

endpackage

// File: rtl/adder_sum_stage_sum_flag_calc.sv
// Combinational sum/flag formation from prefix-adder half-sum and carries.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the consumer registers the result.
//
// Ports:
//   half_sum_i  per-bit a ^ b (b already inverted for subtract)
//   g_pref_i    prefix carries; index 0 = carry-in, k = carry into bit k
//   size_i      operand size selector (SZ_B / SZ_H / SZ_W, 11 = word)
//   sum_o       result, zero above the selected width
//   flags_o     packed {N,Z,V,C} at FLAG_* positions
module adder_sum_stage_sum_flag_calc
  import adder_sum_stage_pkg::*;
#(
  parameter int DATA_W = LEN_DATA
) (
  input  logic [DATA_W-1:0] half_sum_i,
  input  logic [DATA_W:0]   g_pref_i,
  input  logic [1:0]        size_i,
  output logic [DATA_W-1:0] sum_o,
  output logic [3:0]        flags_o
);

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] sum_d;
  logic              c_d;
  logic              v_d;
  logic              n_d;

  always_comb begin
    mask = '0;
    c_d  = 1'b0;
    v_d  = 1'b0;
    n_d  = 1'b0;
    // Carries above the selected width are ignored here; the mask keeps
    // any junk in the upper prefix bits out of the result.
    case (size_i)
      SZ_B: begin
        mask = DATA_W'(32'h0000_00FF);
        c_d  = g_pref_i[8];
        v_d  = g_pref_i[7] ^ g_pref_i[8];
        n_d  = half_sum_i[7] ^ g_pref_i[7];
      end
      SZ_H: begin
        mask = DATA_W'(32'h0000_FFFF);
        c_d  = g_pref_i[16];
        v_d  = g_pref_i[15] ^ g_pref_i[16];
        n_d  = half_sum_i[15] ^ g_pref_i[15];
      end
      default: begin
        mask = DATA_W'(32'hFFFF_FFFF);
        c_d  = g_pref_i[32];
        v_d  = g_pref_i[31] ^ g_pref_i[32];
        n_d  = half_sum_i[31] ^ g_pref_i[31];
      end
    endcase
    sum_d = (half_sum_i ^ g_pref_i[DATA_W-1:0]) & mask;
  end

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = c_d;
    flags_o[FLAG_V] = v_d;
    // Upper bits are already masked to zero, so a full-width NOR is exact.
    flags_o[FLAG_Z] = ~|sum_d;
    flags_o[FLAG_N] = n_d;
  end

  assign sum_o = sum_d;

endmodule

// File: rtl/adder_sum_stage.sv
// Final registered stage of the prefix adder: sum + C/V/Z/N behind a skid buffer.
// Latency: 1 cycle from accept to outputs when the buffer is empty.
// Backpressure: 2-entry skid, in_ready_o registered (SKID_EN=1); else out_ready_o | ~out_valid.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i / in_ready_o upstream handshake
//   half_sum_i, g_pref_i    prefix adder outputs for the beat
//   size_i                  operand size, travels with the beat
//   flush_i                 drop every held beat (priority over accept/pop)
//   out_valid_o/out_ready_i downstream handshake
//   sum_o, flag_[cvzn]_o    registered result and flags
module adder_sum_stage
  import adder_sum_stage_pkg::*;
#(
  parameter int DATA_W  = LEN_DATA,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] half_sum_i,
  input  logic [DATA_W:0]   g_pref_i,
  input  logic [1:0]        size_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              flag_c_o,
  output logic              flag_v_o,
  output logic              flag_z_o,
  output logic              flag_n_o
);

  logic [DATA_W-1:0] res_sum_d;
  logic [3:0]        res_flags_d;

  adder_sum_stage_sum_flag_calc #(
    .DATA_W (DATA_W)
  ) u_sum_flag_calc (
    .half_sum_i (half_sum_i),
    .g_pref_i   (g_pref_i),
    .size_i     (size_i),
    .sum_o      (res_sum_d),
    .flags_o    (res_flags_d)
  );

  skid_state_e       state_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] out_sum_q;
  logic [3:0]        out_flags_q;
  logic [DATA_W-1:0] skid_sum_q;
  logic [3:0]        skid_flags_q;

  logic accept;
  logic pop;

  // Without the skid entry, ready looks through to the downstream ready;
  // it still never depends on in_valid_i.
  assign in_ready_o = SKID_EN ? in_ready_q : (out_ready_i | ~out_valid_q);
  assign accept     = in_valid_i & in_ready_o;
  assign pop        = out_valid_q & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      out_sum_q    <= '0;
      out_flags_q  <= '0;
      skid_sum_q   <= '0;
      skid_flags_q <= '0;
    end else if (flush_i) begin
      // Data registers keep stale contents; out_valid qualifies them.
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_sum_q   <= res_sum_d;
            out_flags_q <= res_flags_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            out_sum_q   <= res_sum_d;
            out_flags_q <= res_flags_d;
          end else if (accept) begin
            // Output is stalled: park the new beat behind it.
            skid_sum_q   <= res_sum_d;
            skid_flags_q <= res_flags_d;
            state_q      <= ST_TWO;
            in_ready_q   <= 1'b0;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            out_sum_q   <= skid_sum_q;
            out_flags_q <= skid_flags_q;
            state_q     <= ST_ONE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign sum_o       = out_sum_q;
  assign flag_c_o    = out_flags_q[FLAG_C];
  assign flag_v_o    = out_flags_q[FLAG_V];
  assign flag_z_o    = out_flags_q[FLAG_Z];
  assign flag_n_o    = out_flags_q[FLAG_N];

endmodule

// File: tb/tb_adder_sum_stage.sv
// Self-checking bench for adder_sum_stage: directed steps with a scoreboard
// of expected {N,Z,V,C,sum} values computed from the operands by plain addition.
module tb_adder_sum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] half_sum;
  logic [32:0] g_pref;
  logic [1:0]  size;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        flag_c, flag_v, flag_z, flag_n;

  always #5 clk = ~clk;

  adder_sum_stage #(
    .DATA_W  (32),
    .SKID_EN (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .half_sum_i  (half_sum),
    .g_pref_i    (g_pref),
    .size_i      (size),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .flag_c_o    (flag_c),
    .flag_v_o    (flag_v),
    .flag_z_o    (flag_z),
    .flag_n_o    (flag_n)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int total_waits = 0;
  logic [35:0] sb[$];
  logic [35:0] cur_exp;

  // Reference: {n, z, v, c, sum} of a + b + cin at the selected width.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic [1:0] sz);
    int w;
    logic [31:0] mask;
    logic [32:0] full;
    logic [31:0] s;
    logic c, v, z, n;
    w    = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full = {1'b0, a & mask} + {1'b0, b & mask} + {32'h0, cin};
    s    = full[31:0] & mask;
    c    = full[w];
    n    = s[w-1];
    v    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    z    = (s == 32'h0);
    return {n, z, v, c, s};
  endfunction

  // Builds DUT inputs by ripple carry up to the selected width and fills the
  // carries above it with random junk that must be ignored.
  task automatic set_beat(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [1:0] sz);
    int w;
    logic [32:0] g;
    w    = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
    g    = '0;
    g[0] = cin;
    for (int k = 0; k < w; k++) g[k+1] = (a[k] & b[k]) | ((a[k] ^ b[k]) & g[k]);
    for (int k = w + 1; k <= 32; k++) g[k] = 1'($urandom);
    half_sum = a ^ b;
    g_pref   = g;
    size     = sz;
    cur_exp  = model(a, b, cin, sz);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic [1:0] sz);
    int waits;
    set_beat(a, b, cin, sz);
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    total_waits += waits;
    n_checks++;
    assert (in_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL send_accept observed in_ready=%b expected 1", in_ready);
    end
    if (in_ready === 1'b1) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain observed pending=%0d expected 0", sb.size());
    end
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected beat.
  always @(negedge clk) begin
    logic [35:0] exp_v;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat observed sum=%h expected no output", sum);
      end
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        n_checks++;
        n_out++;
        assert ({flag_n, flag_z, flag_v, flag_c, sum} === exp_v) else begin
          n_fail++;
          $error("FAIL beat observed nzvc=%b sum=%h expected nzvc=%b sum=%h",
                 {flag_n, flag_z, flag_v, flag_c}, sum, exp_v[35:32], exp_v[31:0]);
        end
      end
    end
  end

  initial begin
    logic [35:0] exp_hold;
    int out_before;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    half_sum = '0; g_pref = '0; size = 2'b10;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    n_checks++;
    assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL rst_out_valid observed %b expected 0", out_valid); end
    n_checks++;
    assert (in_ready === 1'b1) else begin n_fail++; $error("FAIL rst_in_ready observed %b expected 1", in_ready); end
    n_checks++;
    assert ({flag_n, flag_z, flag_v, flag_c, sum} === 36'h0) else begin
      n_fail++; $error("FAIL rst_data observed nzvc=%b sum=%h expected 0", {flag_n, flag_z, flag_v, flag_c}, sum);
    end
    @(posedge clk); #1;

    // 32-bit carry out to zero; outputs valid one cycle after accept
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b10);
    @(negedge clk);
    n_checks++;
    assert (out_valid === 1'b1) else begin n_fail++; $error("FAIL latency observed out_valid=%b expected 1", out_valid); end
    @(posedge clk); #1;
    // 8-bit signed overflow, junk in upper operand bits and carries
    send(32'hABCD_127F, 32'h5500_0001, 1'b0, 2'b00);
    // 16-bit subtract 5 - 7
    send(32'h0000_0005, ~32'h0000_0007, 1'b1, 2'b01);
    // Reserved size decodes as 32-bit
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 2'b11);
    drain();

    // Stall: two beats accepted, third refused while output held
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h0000_1234, 32'h0000_4321, 1'b0, 2'b01);
    exp_hold = cur_exp;
    send(32'h0000_00FF, 32'h0000_00FF, 1'b1, 2'b00);
    set_beat(32'h8000_0000, 32'h8000_0000, 1'b0, 2'b10);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      assert (in_ready === 1'b0) else begin n_fail++; $error("FAIL stall_in_ready observed %b expected 0", in_ready); end
      n_checks++;
      assert (out_valid === 1'b1 && {flag_n, flag_z, flag_v, flag_c, sum} === exp_hold) else begin
        n_fail++; $error("FAIL stall_hold observed v=%b sum=%h expected v=1 sum=%h", out_valid, sum, exp_hold[31:0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 2'b10);
    drain();

    // Back-to-back accept and pop: no wait states, one result per cycle
    @(posedge clk); #1;
    total_waits = 0;
    out_before  = n_out;
    for (int i = 0; i < 10; i++) begin
      send($urandom, $urandom, 1'($urandom), 2'($urandom_range(0, 3)));
    end
    @(negedge clk); #1;
    n_checks++;
    assert (total_waits == 0) else begin n_fail++; $error("FAIL b2b_waits observed %0d expected 0", total_waits); end
    n_checks++;
    assert (n_out - out_before == 10) else begin n_fail++; $error("FAIL b2b_count observed %0d expected 10", n_out - out_before); end
    drain();

    // Flush while holding two beats; a beat offered alongside is dropped
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h0000_0011, 32'h0000_0022, 1'b0, 2'b10);
    send(32'h0000_0033, 32'h0000_0044, 1'b0, 2'b10);
    set_beat(32'h0000_0055, 32'h0000_0066, 1'b0, 2'b10);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    n_checks++;
    assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL flush_out_valid observed %b expected 0", out_valid); end
    n_checks++;
    assert (in_ready === 1'b1) else begin n_fail++; $error("FAIL flush_in_ready observed %b expected 1", in_ready); end
    out_before = n_out;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    assert (n_out == out_before) else begin n_fail++; $error("FAIL flush_leak observed %0d beats expected 0", n_out - out_before); end

    // Reset while holding two beats
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h0000_0077, 32'h0000_0088, 1'b0, 2'b10);
    send(32'h0000_0099, 32'h0000_00AA, 1'b0, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    n_checks++;
    assert (out_valid === 1'b0 && in_ready === 1'b1) else begin
      n_fail++; $error("FAIL rst2_hs observed v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
    n_checks++;
    assert ({flag_n, flag_z, flag_v, flag_c, sum} === 36'h0) else begin
      n_fail++; $error("FAIL rst2_data observed sum=%h expected 0", sum);
    end
    out_before = n_out;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    assert (n_out == out_before) else begin n_fail++; $error("FAIL rst_leak observed %0d beats expected 0", n_out - out_before); end

    // Still functional after reset
    @(posedge clk); #1;
    send(32'h0000_0080, 32'h0000_0080, 1'b0, 2'b00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_sum_stage.md
Name: adder_sum_stage

Overview:
- Final, registered stage of the ALU parallel-prefix adder. Sits directly downstream of the last prefix stage (stage 5).
- Consumes the masked group-generate vector and the per-bit half-sum. Forms the sum, carry, overflow, zero and negative flags for the selected operand width.
- Registers the result behind a valid/ready handshake, with a 2-entry skid buffer so the ALU pipeline can stall without bubbles.

Parameters:
- DATA_W, `LEN_DATA, operand width in bits. Prefix vectors are DATA_W+1 bits wide.
- SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register with in_ready = out_ready | ~out_valid.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream stage holds valid prefix data
- in_ready  output  1  this stage can accept a beat this cycle
- half_sum  input  DATA_W  a ^ b per operand bit (b already inverted for subtract)
- g_pref  input  DATA_W+1  masked prefix generate; index 0 = carry-in, index k = carry into operand bit k
- size  input  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved (treated as 32-bit)
- flush  input  1  synchronous drop of all held beats
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream accepts result
- sum  output  DATA_W  adder result, zero above selected width
- flag_c  output  1  carry out of selected width's MSB
- flag_v  output  1  signed overflow at selected width
- flag_z  output  1  sum[W-1:0] == 0
- flag_n  output  1  sum[W-1]

Behaviour:
- W = 8/16/32 per size; size is sampled with the beat and travels with it.
- Combinational front end, per beat:
  - sum[j] = half_sum[j] ^ g_pref[j] for j < W; sum[j] = 0 for j >= W.
  - c = g_pref[W].
  - v = g_pref[W-1] ^ g_pref[W].
  - z = ~|sum[W-1:0].
  - n = sum[W-1].
- Width rule: no arithmetic beyond the XOR. Bits of g_pref above W are ignored even if nonzero (prefix mask is upstream's responsibility).
- Latency: 1 cycle. A beat accepted at edge t (in_valid & in_ready) is on the outputs after edge t, if the buffer was empty.
- Handshake:
  - Transfer occurs when valid & ready are both high at a rising edge.
  - out_valid, sum and flags are held stable while out_valid & ~out_ready.
  - in_ready does not depend combinationally on in_valid.
- Skid FSM (SKID_EN=1), states EMPTY, ONE, TWO:
  - EMPTY: in_ready=1, out_valid=0. Accept → ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept & ~pop → TWO.
    - Pop & ~accept → EMPTY.
    - Accept & pop → ONE, new beat on outputs.
  - TWO: in_ready=0, out_valid=1. Pop → ONE; skid entry moves to the output register.
  - in_ready is registered, equal to (state != TWO).
- SKID_EN=0: only EMPTY/ONE exist. Accept & pop in the same cycle is allowed.
- Ordering: strictly FIFO; beats are never reordered or duplicated.
- flush: next state EMPTY and out_valid=0. A beat offered in the same cycle is dropped. flush has priority over accept and pop.
- Reset: next state EMPTY; out_valid=0, in_ready=1 after reset; sum=0, flags=0. Reset mid-stall discards held beats.
- Data registers are cleared on reset only. After flush or pop they may hold stale data, but out_valid=0 qualifies them.

Decomposition:
- Shared alu package `define header:
  - size encodings SZ_B/SZ_H/SZ_W.
  - flag bit positions (C,V,Z,N) for the status-register packing.
  - skid state encoding.
- Sub-module sum_flag_calc: purely combinational XOR plus flag logic, taking half_sum, g_pref and size.
- The top level holds the skid FSM and registers.

Test Plan:
- 32-bit 0xFFFFFFFF+0x00000001, cin=0, out_ready=1 → sum=0, C=1, V=0, Z=1, N=0 one cycle after accept.
- 8-bit 0x7F+0x01 → sum=0x00000080, C=0, V=1, N=1, Z=0; upper 24 bits 0.
- 16-bit subtract 0x0005-0x0007 (b inverted, cin=1) → sum=0x0000FFFE, C=0, V=0, N=1.
- Stall: out_ready=0 for 3 cycles with 3 beats offered → accepts 2, in_ready=0 on the 3rd; release → beats emerge in order, no loss.
- Simultaneous accept & pop in ONE state for 10 back-to-back beats → one result per cycle, in_ready stays 1.
- flush (and separately rst) asserted while in TWO → out_valid=0 next cycle, in_ready=1, no held beat ever emitted.
